// File: rtl/img_port_arbiter.sv
// img_port_arbiter: round-robin valid/ready arbiter sharing the image row SRAM read port.
// Define IMG_ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-wins priority.
module img_port_arbiter #(
   parameter int NREQ   = 4,
   parameter int ADDR_W = 9,
   parameter int ROWS   = 480,
   parameter int ID_W   = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ-1:0]        req_lock,
   output logic [NREQ-1:0]        gnt,
   output logic [ADDR_W-1:0]      img_addr,
   output logic                   rd_valid,
   output logic [ID_W-1:0]        rd_id,
   output logic                   busy,
   output logic                   addr_err,
   input  logic                   err_clr
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROWS - 1);
   logic [NREQ-1:0]   act;
   logic [ID_W-1:0]   win, lock_own, iss_id;
   logic              hit, lock_v, lock_hit, iss_v, bad;
   logic [ADDR_W-1:0] sel_addr;
   assign act      = req & {NREQ{en}};
   assign lock_hit = lock_v & act[lock_own] & req_lock[lock_own];
`ifdef IMG_ARB_FIXED_PRIO_EN
   always_comb begin
      win = lock_own;
      hit = lock_hit;
      for (int k = NREQ - 1; k >= 0; k--)
         if (!lock_hit && act[k]) begin
            hit = 1'b1;
            win = ID_W'(k);
         end
   end
`else
   logic [ID_W-1:0] ptr;
   // descending scan so the requester closest to ptr is assigned last and wins
   always_comb begin
      win = lock_own;
      hit = lock_hit;
      for (int k = NREQ - 1; k >= 0; k--)
         if (!lock_hit && act[(int'(ptr) + k) % NREQ]) begin
            hit = 1'b1;
            win = ID_W'((int'(ptr) + k) % NREQ);
         end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) ptr <= '0;
      else if (hit && !lock_hit) ptr <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
`endif
   assign gnt      = (hit && !rst) ? NREQ'(1) << win : '0;
   assign sel_addr = req_addr[int'(win)*ADDR_W +: ADDR_W];
   assign bad      = sel_addr > LAST;
   assign busy     = iss_v | rd_valid;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         lock_v   <= 1'b0;
         lock_own <= '0;
      end else if (hit && req_lock[win]) begin
         lock_v   <= 1'b1;
         lock_own <= win;
      end else if (lock_v && !(req[lock_own] && req_lock[lock_own])) lock_v <= 1'b0;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         img_addr <= '0;
         iss_v    <= 1'b0;
         iss_id   <= '0;
         rd_valid <= 1'b0;
         rd_id    <= '0;
      end else begin
         iss_v    <= hit;
         rd_valid <= iss_v;
         rd_id    <= iss_id;
         if (hit) begin
            img_addr <= bad ? LAST : sel_addr;
            iss_id   <= win;
         end
      end
   // a new error on the same edge as err_clr keeps the flag set
   always_ff @(posedge clk or posedge rst)
      if (rst) addr_err <= 1'b0;
      else if (hit && bad) addr_err <= 1'b1;
      else if (err_clr) addr_err <= 1'b0;
endmodule

// File: tb/tb_img_port_arbiter.sv
// tb_img_port_arbiter: directed and random stimulus checked against a beat-level reference model.
module tb_img_port_arbiter;
   localparam int NREQ = 4, ADDR_W = 9, ROWS = 480, ID_W = 2;
   logic clk = 1'b0, rst, en, err_clr;
   logic [NREQ-1:0] req, req_lock, gnt;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [ADDR_W-1:0] img_addr;
   logic rd_valid, busy, addr_err;
   logic [ID_W-1:0] rd_id;
   int addr [NREQ];
   int checks = 0, errors = 0;
   int m_ptr, m_own, s1_id, s2_id, m_addr, last_w;
   bit m_lock, s1_v, s2_v, m_err;
   logic [NREQ-1:0] g_seen;

   img_port_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .ROWS(ROWS), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst), .en(en), .req(req), .req_addr(req_addr), .req_lock(req_lock),
      .gnt(gnt), .img_addr(img_addr), .rd_valid(rd_valid), .rd_id(rd_id), .busy(busy),
      .addr_err(addr_err), .err_clr(err_clr));

   always #5 clk = ~clk;

   always_comb
      for (int i = 0; i < NREQ; i++) req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(addr[i]);

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_lock = 0; m_own = 0; s1_v = 0; s1_id = 0; s2_v = 0; s2_id = 0;
      m_addr = 0; m_err = 0; last_w = -1;
   endtask

   function automatic int model_win();
      int start;
      if (!en) return -1;
      if (m_lock && req[m_own] && req_lock[m_own]) return m_own;
`ifdef IMG_ARB_FIXED_PRIO_EN
      start = 0;
`else
      start = m_ptr;
`endif
      for (int k = 0; k < NREQ; k++)
         if (req[(start + k) % NREQ]) return (start + k) % NREQ;
      return -1;
   endfunction

   // inputs are set just after a falling edge; one full clock is checked here
   task automatic cycle();
      int w;
      bit locked_win;
      #1;
      w = model_win();
      g_seen = gnt;
      check("gnt", 32'(gnt), (w < 0) ? 0 : (1 << w));
      locked_win = m_lock && en && req[m_own] && req_lock[m_own];
      @(posedge clk);
      s2_v = s1_v;
      s2_id = s1_id;
      s1_v = (w >= 0);
      if (w >= 0) begin
         s1_id = w;
         m_addr = (addr[w] >= ROWS) ? ROWS - 1 : addr[w];
         if (addr[w] >= ROWS) m_err = 1;
         else if (err_clr) m_err = 0;
         if (!locked_win) m_ptr = (w + 1) % NREQ;
      end else if (err_clr) m_err = 0;
      if (w >= 0 && req_lock[w]) begin
         m_lock = 1;
         m_own = w;
      end else if (m_lock && !(req[m_own] && req_lock[m_own])) m_lock = 0;
      last_w = w;
      #1;
      check("img_addr", 32'(img_addr), m_addr);
      check("rd_valid", 32'(rd_valid), 32'(s2_v));
      if (s2_v) check("rd_id", 32'(rd_id), s2_id);
      check("busy", 32'(busy), 32'(s1_v | s2_v));
      check("addr_err", 32'(addr_err), 32'(m_err));
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req = '0; req_lock = '0; err_clr = 0;
      for (int i = 0; i < NREQ; i++) addr[i] = 0;
   endtask

   task automatic pulse_reset();
      #2 rst = 1;
      #1;
      check("rst_gnt", 32'(gnt), 0);
      check("rst_rd_valid", 32'(rd_valid), 0);
      check("rst_rd_id", 32'(rd_id), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_img_addr", 32'(img_addr), 0);
      check("rst_addr_err", 32'(addr_err), 0);
      model_reset();
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      rst = 1; en = 0;
      idle_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      pulse_reset();
      en = 1;
      // single beat from requester 2
      req = 4'b0100; addr[2] = 17;
      cycle();
      check("single_gnt", 32'(g_seen), 32'h4);
      check("single_addr", 32'(img_addr), 17);
      req = '0;
      cycle();
      check("single_rd_valid", 32'(rd_valid), 1);
      check("single_rd_id", 32'(rd_id), 2);
      // reset while a beat is in flight
      req = 4'b0010; addr[1] = 33;
      cycle();
      req = '0;
      pulse_reset();
      cycle();
      cycle();
      // all four requesting, no lock
      req = 4'b1111;
      for (int i = 0; i < NREQ; i++) addr[i] = 100 + i;
      for (int i = 0; i < 8; i++) begin
         cycle();
`ifndef IMG_ARB_FIXED_PRIO_EN
         check("rr_order", 32'(g_seen), 1 << (i % NREQ));
`endif
      end
      // lock by requester 1 for five beats
      req = 4'b0001;
      cycle();
      req = 4'b1111; req_lock = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("lock_gnt", 32'(g_seen), 32'h2);
      end
      req_lock = '0;
      cycle();
`ifndef IMG_ARB_FIXED_PRIO_EN
      check("lock_next", 32'(g_seen), 32'h4);
`endif
      // out-of-range address, then clear colliding with a new error
      req = 4'b1000; addr[3] = 480;
      cycle();
      check("err_clamp", 32'(img_addr), 479);
      check("err_flag", 32'(addr_err), 1);
      addr[3] = 500; err_clr = 1;
      cycle();
      check("err_set_wins", 32'(addr_err), 1);
      req = '0;
      cycle();
      check("err_cleared", 32'(addr_err), 0);
      err_clr = 0;
      // en drop during continuous requests
      req = 4'b1111;
      for (int i = 0; i < NREQ; i++) addr[i] = 200 + i;
      repeat (3) cycle();
      en = 0;
      cycle();
      check("en_low_gnt", 32'(g_seen), 0);
      cycle();
      check("en_low_busy", 32'(busy), 0);
`ifdef IMG_ARB_FIXED_PRIO_EN
      en = 1; req = 4'b1010;
      repeat (4) begin
         cycle();
         check("fixed_gnt", 32'(g_seen), 32'h2);
      end
`endif
      // random traffic honoring the hold-until-granted handshake
      en = 1; idle_inputs();
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < NREQ; i++)
            if (!req[i] || i == last_w) begin
               req[i] = ($urandom_range(0, 2) != 0);
               addr[i] = ($urandom_range(0, 15) == 0) ? $urandom_range(ROWS, 511) : $urandom_range(0, ROWS - 1);
            end
         for (int i = 0; i < NREQ; i++) req_lock[i] = ($urandom_range(0, 5) == 0);
         en = ($urandom_range(0, 9) != 0);
         err_clr = ($urandom_range(0, 7) == 0);
         cycle();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
